// File: rtl/pacote_cronometro.sv
// Shared definitions for the stopwatch stages: FSM state encoding, default
// timing constants and the counter-width helper.
package pacote_cronometro;

   typedef enum logic [1:0] {
      PARADO   = 2'b00,
      CONTANDO = 2'b01,
      PAUSADO  = 2'b10,
      FIM      = 2'b11
   } estado_t;

   localparam int CICLOS_SEGUNDO_PADRAO   = 50000000;
   localparam int CICLOS_VARREDURA_PADRAO = 50000;
   localparam int CICLOS_DEBOUNCE_PADRAO  = 500000;

   // A parameter of 1 would give a zero-width counter; keep at least one bit.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/filtro_botao.sv
// Pushbutton conditioner: 2-flop synchronizer, stability filter and a one-cycle
// press pulse on the filtered 1->0 edge, 2 + CICLOS_DEBOUNCE cycles after the pin.
module filtro_botao
   import pacote_cronometro::*;
#(
   parameter int CICLOS_DEBOUNCE = CICLOS_DEBOUNCE_PADRAO
) (
   input  logic clock,
   input  logic resetN,
   input  logic botao_n,
   output logic pressao
);

   localparam int              LC       = largura(CICLOS_DEBOUNCE);
   localparam logic [LC-1:0]   CONT_MAX = LC'(CICLOS_DEBOUNCE - 1);

   logic          sinc1_q, sinc1_d;
   logic          sinc2_q, sinc2_d;
   logic [LC-1:0] cont_q, cont_d;
   logic          filtrado_q, filtrado_d;
   logic          filtrado_ant_q, filtrado_ant_d;
   logic          valido_q, valido_d;
   logic          armado_q, armado_d;
   logic          pulso_q, pulso_d;

   always_comb begin
      sinc1_d        = botao_n;
      sinc2_d        = sinc1_q;
      cont_d         = cont_q;
      filtrado_d     = filtrado_q;
      filtrado_ant_d = filtrado_q;
      valido_d       = 1'b1;

      if (sinc2_q == filtrado_q) begin
         cont_d = '0;
      end else if (cont_q == CONT_MAX) begin
         filtrado_d = sinc2_q;
         cont_d     = '0;
      end else begin
         cont_d = cont_q + LC'(1);
      end

      // A button held through reset must be seen released before it may fire.
      armado_d = armado_q | (valido_q & sinc1_q);
      pulso_d  = filtrado_ant_q & ~filtrado_q & armado_q;
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         sinc1_q        <= 1'b1;
         sinc2_q        <= 1'b1;
         cont_q         <= '0;
         filtrado_q     <= 1'b1;
         filtrado_ant_q <= 1'b1;
         valido_q       <= 1'b0;
         armado_q       <= 1'b0;
         pulso_q        <= 1'b0;
      end else begin
         sinc1_q        <= sinc1_d;
         sinc2_q        <= sinc2_d;
         cont_q         <= cont_d;
         filtrado_q     <= filtrado_d;
         filtrado_ant_q <= filtrado_ant_d;
         valido_q       <= valido_d;
         armado_q       <= armado_d;
         pulso_q        <= pulso_d;
      end
   end

   assign pressao = pulso_q;

endmodule

// File: rtl/controle_tempo.sv
// Stopwatch control: debounced start/pause and clear buttons drive a 4-state FSM,
// a per-second enable prescaler that runs only while counting, and a free-running scan tick.
module controle_tempo
   import pacote_cronometro::*;
#(
   parameter int CICLOS_SEGUNDO   = CICLOS_SEGUNDO_PADRAO,
   parameter int CICLOS_VARREDURA = CICLOS_VARREDURA_PADRAO,
   parameter int CICLOS_DEBOUNCE  = CICLOS_DEBOUNCE_PADRAO
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       botaoIniciar,
   input  logic       botaoZerar,
   input  logic       fimContagem,
   output logic       umSegundo,
   output logic       displayTick,
   output logic       zerar,
   output logic [1:0] estado
);

   localparam int            LS      = largura(CICLOS_SEGUNDO);
   localparam int            LV      = largura(CICLOS_VARREDURA);
   localparam logic [LS-1:0] SEG_MAX = LS'(CICLOS_SEGUNDO - 1);
   localparam logic [LV-1:0] VAR_MAX = LV'(CICLOS_VARREDURA - 1);

   logic ev_iniciar;
   logic ev_zerar;

   estado_t       estado_q, estado_d;
   logic          zerar_q, zerar_d;
   logic [LS-1:0] seg_q, seg_d;
   logic          um_q, um_d;
   logic [LV-1:0] varre_q, varre_d;
   logic          tick_q, tick_d;

   filtro_botao #(.CICLOS_DEBOUNCE(CICLOS_DEBOUNCE)) u_filtro_iniciar (
      .clock   (clock),
      .resetN  (resetN),
      .botao_n (botaoIniciar),
      .pressao (ev_iniciar)
   );

   filtro_botao #(.CICLOS_DEBOUNCE(CICLOS_DEBOUNCE)) u_filtro_zerar (
      .clock   (clock),
      .resetN  (resetN),
      .botao_n (botaoZerar),
      .pressao (ev_zerar)
   );

   always_comb begin
      estado_d = estado_q;
      zerar_d  = ev_zerar;

      if (ev_zerar) begin
         estado_d = PARADO;
      end else begin
         case (estado_q)
            PARADO:   if (ev_iniciar && !fimContagem) estado_d = CONTANDO;
            CONTANDO: begin
               if (fimContagem)     estado_d = FIM;
               else if (ev_iniciar) estado_d = PAUSADO;
            end
            PAUSADO:  if (ev_iniciar) estado_d = CONTANDO;
            FIM:      estado_d = FIM;
            default:  estado_d = PARADO;
         endcase
      end
   end

   // The fraction of a second is dropped whenever we land in PARADO or FIM.
   always_comb begin
      seg_d = seg_q;
      um_d  = 1'b0;
      if (estado_d == PARADO || estado_d == FIM) begin
         seg_d = '0;
      end else if (estado_q == CONTANDO) begin
         if (seg_q == SEG_MAX) begin
            seg_d = '0;
            um_d  = 1'b1;
         end else begin
            seg_d = seg_q + LS'(1);
         end
      end
   end

   always_comb begin
      tick_d = 1'b0;
      if (varre_q == VAR_MAX) begin
         varre_d = '0;
         tick_d  = 1'b1;
      end else begin
         varre_d = varre_q + LV'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         estado_q <= PARADO;
         zerar_q  <= 1'b0;
         seg_q    <= '0;
         um_q     <= 1'b0;
         varre_q  <= '0;
         tick_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         zerar_q  <= zerar_d;
         seg_q    <= seg_d;
         um_q     <= um_d;
         varre_q  <= varre_d;
         tick_q   <= tick_d;
      end
   end

   assign umSegundo   = um_q & ~fimContagem;
   assign displayTick = tick_q;
   assign zerar       = zerar_q;
   assign estado      = estado_q;

endmodule

// File: tb/tb_controle_tempo.sv
// Bench for controle_tempo: directed scenarios followed by random button/fim
// traffic, every cycle compared against a behavioural model of the stopwatch rules.
module tb_controle_tempo;

   localparam int S = 10;
   localparam int V = 4;
   localparam int D = 3;

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic       botaoIniciar = 1'b1;
   logic       botaoZerar = 1'b1;
   logic       fimContagem = 1'b0;
   logic       umSegundo, displayTick, zerar;
   logic [1:0] estado;

   controle_tempo #(
      .CICLOS_SEGUNDO   (S),
      .CICLOS_VARREDURA (V),
      .CICLOS_DEBOUNCE  (D)
   ) dut (
      .clock        (clock),
      .resetN       (resetN),
      .botaoIniciar (botaoIniciar),
      .botaoZerar   (botaoZerar),
      .fimContagem  (fimContagem),
      .umSegundo    (umSegundo),
      .displayTick  (displayTick),
      .zerar        (zerar),
      .estado       (estado)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model state: modes as 0..3, cycles counted while running,
   // cycles since reset, raw pin history per button (bit 0 = newest sample).
   int          m_estado;
   int          m_contados;
   int          m_ciclos;
   bit          m_um, m_tick, m_zerar;
   logic [31:0] m_bruto [2];
   bit          m_filt [2];
   bit          m_armado [2];
   bit [1:0]    m_pend [2];

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      assert (obs === esp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, esp, cyc);
      end
   endtask

   // Button rule: filtered level flips once the synchronized (2-cycle-late) pin has
   // differed from it for D samples; an armed falling flip acts on the FSM 2 edges later.
   task modelo_botao(input int b, input logic pino, output bit ev);
      bit todos;
      bit queda;
      ev = m_pend[b][1];
      m_bruto[b] = {m_bruto[b][30:0], pino};
      todos = 1'b1;
      for (int i = 0; i < D; i++)
         if (m_bruto[b][2+i] == m_filt[b]) todos = 1'b0;
      queda = 1'b0;
      if (todos) begin
         m_filt[b] = ~m_filt[b];
         queda = !m_filt[b] && m_armado[b];
      end
      m_pend[b] = {m_pend[b][0], queda};
      if (pino) m_armado[b] = 1'b1;
   endtask

   task modelo();
      bit ev_i, ev_z;
      int antigo;
      if (!resetN) begin
         m_estado = 0; m_contados = 0; m_ciclos = 0;
         m_um = 0; m_tick = 0; m_zerar = 0;
         for (int b = 0; b < 2; b++) begin
            m_bruto[b] = '1; m_filt[b] = 1'b1; m_armado[b] = 1'b0; m_pend[b] = 2'b00;
         end
      end else begin
         modelo_botao(0, botaoIniciar, ev_i);
         modelo_botao(1, botaoZerar, ev_z);
         antigo  = m_estado;
         m_zerar = ev_z;
         if (ev_z)                             m_estado = 0;
         else if (antigo == 1 && fimContagem)  m_estado = 3;
         else if (ev_i) begin
            if (antigo == 0 && !fimContagem)   m_estado = 1;
            else if (antigo == 1)              m_estado = 2;
            else if (antigo == 2)              m_estado = 1;
         end
         m_um = 0;
         if (m_estado == 0 || m_estado == 3) m_contados = 0;
         else if (antigo == 1) begin
            m_contados++;
            m_um = (m_contados % S == 0);
         end
         m_ciclos++;
         m_tick = (m_ciclos % V == 0);
      end
   endtask

   task passo();
      @(posedge clock);
      modelo();
      cyc++;
      #1;
      verifica("estado", estado, m_estado);
      verifica("umSegundo", umSegundo, m_um & !fimContagem);
      verifica("displayTick", displayTick, m_tick);
      verifica("zerar", zerar, m_zerar);
   endtask

   initial begin
      int ticks, ult, espaco_ok, ums, t0, entrada, pausa, retorno, prox, zs, saida, mudou;
      int pulsos[$];
      int ri, rz, rf;

      // Reset
      resetN = 1'b0;
      passo(); passo();
      verifica("reset_estado", estado, 2'b00);
      verifica("reset_um", umSegundo, 1'b0);
      verifica("reset_tick", displayTick, 1'b0);
      verifica("reset_zerar", zerar, 1'b0);
      resetN = 1'b1;

      // Idle: scan ticks only
      ticks = 0; ult = -1; espaco_ok = 1; ums = 0;
      repeat (40) begin
         passo();
         if (displayTick) begin
            if (ult >= 0 && cyc - ult != V) espaco_ok = 0;
            ult = cyc;
            ticks++;
         end
         if (umSegundo) ums++;
      end
      verifica("idle_ticks", ticks, 10);
      verifica("idle_espaco", espaco_ok, 1);
      verifica("idle_um", ums, 0);
      verifica("idle_estado", estado, 2'b00);

      // Start: 8-cycle press, entry latency and second pulses
      botaoIniciar = 1'b0;
      t0 = cyc + 1; entrada = -1;
      for (int i = 0; i < 45; i++) begin
         passo();
         if (i == 7) botaoIniciar = 1'b1;
         if (entrada < 0 && estado == 2'b01) entrada = cyc;
         if (umSegundo) pulsos.push_back(cyc);
      end
      verifica("inicio_latencia", entrada - t0, 6);
      verifica("inicio_num_um", pulsos.size(), 3);
      for (int i = 0; i < 3; i++) begin
         prox = (pulsos.size() > i) ? pulsos[i] - entrada : -1;
         verifica("inicio_um_offset", prox, 10 * (i + 1));
      end

      // Back to PARADO
      botaoZerar = 1'b0;
      repeat (4) passo();
      botaoZerar = 1'b1;
      repeat (6) passo();
      verifica("zerar_para_parado", estado, 2'b00);

      // Start, pause after 6 counting cycles, hold, resume
      entrada = -1; pausa = -1;
      for (int i = 0; i < 16; i++) begin
         botaoIniciar = (i < 3) ? 1'b0 : (i < 6) ? 1'b1 : (i < 10) ? 1'b0 : 1'b1;
         passo();
         if (entrada < 0 && estado == 2'b01) entrada = cyc;
         if (pausa < 0 && estado == 2'b10) pausa = cyc;
      end
      verifica("pausa_apos_6", pausa - entrada, 6);
      ums = 0;
      repeat (20) begin
         passo();
         if (umSegundo) ums++;
      end
      verifica("pausa_sem_um", ums, 0);
      verifica("pausa_estado", estado, 2'b10);
      botaoIniciar = 1'b0;
      t0 = cyc + 1; retorno = -1; prox = -1;
      for (int i = 0; i < 30; i++) begin
         if (i == 4) botaoIniciar = 1'b1;
         passo();
         if (retorno < 0 && estado == 2'b01) retorno = cyc;
         if (retorno >= 0 && prox < 0 && umSegundo) prox = cyc;
      end
      verifica("retoma_latencia", retorno - t0, 6);
      verifica("retoma_um", prox - retorno, 4);

      // Bouncing button: no event
      for (int i = 0; i < 12; i++) begin
         botaoIniciar = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         passo();
      end
      botaoIniciar = 1'b1;
      repeat (10) passo();
      verifica("toggle_estado", estado, 2'b01);

      // fimContagem together with an iniciar event, then clear
      botaoIniciar = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) botaoIniciar = 1'b1;
         if (i == 6) fimContagem = 1'b1;
         passo();
         if (i == 6) begin
            verifica("fim_estado", estado, 2'b11);
            verifica("fim_sem_um", umSegundo, 1'b0);
         end
      end
      botaoZerar = 1'b0;
      zs = 0; saida = -1;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) botaoZerar = 1'b1;
         passo();
         if (zerar) zs++;
         if (saida < 0 && estado == 2'b00) begin
            saida = cyc;
            verifica("zerar_mesmo_ciclo", zerar, 1'b1);
         end
      end
      verifica("zerar_pulsos", zs, 1);
      verifica("zerar_estado", estado, 2'b00);
      fimContagem = 1'b0;

      // Reset at prescaler value 7 with iniciar held through it
      botaoIniciar = 1'b0;
      entrada = -1;
      for (int i = 0; i < 30; i++) begin
         if (i == 4) botaoIniciar = 1'b1;
         passo();
         if (entrada < 0 && estado == 2'b01) entrada = cyc;
         if (entrada >= 0 && cyc == entrada + 7) break;
      end
      verifica("pre_reset_contando", estado, 2'b01);
      resetN = 1'b0;
      botaoIniciar = 1'b0;
      passo();
      verifica("rst_estado", estado, 2'b00);
      verifica("rst_um", umSegundo, 1'b0);
      verifica("rst_tick", displayTick, 1'b0);
      verifica("rst_zerar", zerar, 1'b0);
      resetN = 1'b1;
      mudou = 0;
      repeat (20) begin
         passo();
         if (estado != 2'b00) mudou = 1;
      end
      verifica("rst_segurado_sem_evento", mudou, 0);
      botaoIniciar = 1'b1;
      repeat (6) passo();
      botaoIniciar = 1'b0;
      repeat (8) passo();
      botaoIniciar = 1'b1;
      repeat (2) passo();
      verifica("pos_reset_inicia", estado, 2'b01);

      // Random traffic against the model
      ri = 0; rz = 0; rf = 0;
      for (int n = 0; n < 1500; n++) begin
         if (ri == 0) begin
            botaoIniciar = 1'($urandom_range(0, 1));
            ri = $urandom_range(1, 10);
         end
         if (rz == 0) begin
            botaoZerar = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            rz = $urandom_range(1, 10);
         end
         if (rf == 0) begin
            fimContagem = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            rf = $urandom_range(1, 15);
         end
         ri--; rz--; rf--;
         passo();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/controle_tempo.md
CONTROLE_TEMPO -- requirements
Module: controle_tempo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock `clock`, reset `resetN`, both sampled on the rising edge only.
REQ-002 Parameter CICLOS_SEGUNDO, default 50000000: clock cycles per umSegundo period.
REQ-003 Parameter CICLOS_VARREDURA, default 50000: clock cycles per displayTick period.
REQ-004 Parameter CICLOS_DEBOUNCE, default 500000: cycles a synchronized button level must stay stable to be accepted.
REQ-005 clock  in  1  system clock.
REQ-006 resetN  in  1  synchronous active-low reset.
REQ-007 botaoIniciar  in  1  raw asynchronous start/pause pushbutton, active-low.
REQ-008 botaoZerar  in  1  raw asynchronous clear pushbutton, active-low.
REQ-009 fimContagem  in  1  from the countdown stage, high while all digits are zero.
REQ-010 umSegundo  out  1  one-cycle enable pulse per counted second.
REQ-011 displayTick  out  1  one-cycle pulse per display-scan step.
REQ-012 zerar  out  1  one-cycle pulse commanding the countdown stage to reload.
REQ-013 estado  out  2  current FSM state.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a stability counter; the filtered level SHALL change only after CICLOS_DEBOUNCE consecutive equal synchronized samples.
REQ-015 A press event SHALL be a one-cycle pulse on the filtered 1->0 transition; release SHALL generate no event; a held button SHALL generate exactly one event.
REQ-016 Latency from the first sampled pin change to the estado change SHALL be exactly 3 + CICLOS_DEBOUNCE cycles.
REQ-017 FSM states: PARADO=00, CONTANDO=01, PAUSADO=10, FIM=11.
REQ-018 PARADO: iniciar with fimContagem=0 -> CONTANDO; iniciar with fimContagem=1 -> stay.
REQ-019 CONTANDO: fimContagem=1 -> FIM; otherwise iniciar -> PAUSADO.
REQ-020 PAUSADO: iniciar -> CONTANDO.
REQ-021 FIM: iniciar ignored.
REQ-022 zerar event in any state -> PARADO, with the zerar output pulsed in the same cycle the state updates.
REQ-023 Priority SHALL be zerar > fimContagem > iniciar for simultaneous events.
REQ-024 The second prescaler SHALL count 0..CICLOS_SEGUNDO-1 only in CONTANDO and hold its value in PAUSADO.
REQ-025 umSegundo SHALL pulse when the second prescaler wraps from CICLOS_SEGUNDO-1 to 0.
REQ-026 The second prescaler SHALL be cleared on entry to PARADO or FIM, so the first umSegundo comes CICLOS_SEGUNDO cycles after entering CONTANDO from PARADO.
REQ-027 umSegundo SHALL be suppressed in any cycle where fimContagem=1.
REQ-028 The scan prescaler SHALL free-run in every state, pulsing displayTick once every CICLOS_VARREDURA cycles.
REQ-029 Counter widths SHALL be $clog2 of each parameter, and wrap SHALL be by compare, never by overflow.

Reset
REQ-030 While resetN=0, the block SHALL force: estado=PARADO; both prescalers=0; umSegundo=displayTick=zerar=0; debounce counters=0.
REQ-031 While resetN=0, synchronizers and filtered levels SHALL be forced to 1 (released), so a button held through reset yields no event until it is released and pressed again.
REQ-032 Reset asserted mid-count SHALL discard the accumulated fraction of a second.

Structure
REQ-033 Package pacote_cronometro SHALL hold the estado typedef/encoding and the default parameter constants, shared with the display and countdown stages.
REQ-034 Button filtering SHALL be sub-module filtro_botao (synchronizer + debounce + press pulse), instantiated twice.

Verification
Bench parameters for all scenarios: CICLOS_SEGUNDO=10, CICLOS_VARREDURA=4, CICLOS_DEBOUNCE=3.
REQ-035 Reset, then idle 40 cycles -> estado=00, umSegundo never high, displayTick exactly 10 pulses spaced 4 cycles.
REQ-036 botaoIniciar low 8 cycles -> estado=01 exactly 6 cycles after first low sample; umSegundo at +10, +20, +30 cycles after entry.
REQ-037 Pause after 6 counting cycles, wait 20, resume -> no umSegundo while paused; next umSegundo 4 cycles after re-entering CONTANDO.
REQ-038 botaoIniciar toggling every 2 cycles for 12 cycles, then high -> estado unchanged, no event.
REQ-039 In CONTANDO, fimContagem=1 in the same cycle as an iniciar event -> estado=11, no umSegundo; then botaoZerar press -> estado=00 with zerar high exactly 1 cycle.
REQ-040 resetN low for 1 cycle at prescaler value 7 -> next cycle estado=00, all outputs 0; a botaoIniciar held low through reset produces no transition.
